// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the instruction-memory
// request/ready handshake, delivers words into IF/ID under the hazard
// unit's stall, and accepts already-resolved redirects.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        im_ready,
  input  logic [31:0] im_rdata,
  output logic        im_req,
  output logic [31:0] im_addr,
  output logic [31:0] pc_add_out,
  output logic        if_id_we,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc,
  output logic        if_id_flush,
  output logic        misalign,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        misalign_q, misalign_d;

  logic [31:0] pc_inc;
  logic [31:0] tgt;
  logic        req_c;
  logic        deliver;
  logic        kill;

  // Redirect targets are forced to word alignment; the low bits only feed misalign.
  assign pc_inc = pc_q + 32'd4;
  assign tgt    = {redirect_pc[31:2], 2'b00};

  // State register and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      buf_q         <= 32'h0;
      misalign_q    <= 1'b0;
      fetch_count_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      buf_q         <= buf_d;
      misalign_q    <= misalign_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Next-state and register updates; a redirect outranks stall and im_ready.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    buf_d         = buf_q;
    misalign_d    = misalign_q | (redirect_valid && (redirect_pc[1:0] != 2'b00));
    fetch_count_d = fetch_count_q + {31'b0, deliver};
    if (deliver) begin
      pc_d = pc_inc;
    end
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect_valid) begin
          pc_d = tgt;
        end
      end
      FETCH: begin
        if (redirect_valid) begin
          pc_d    = tgt;
          // Without a response this cycle the old one is still in flight.
          state_d = im_ready ? FETCH : DRAIN;
        end else if (im_ready && stall) begin
          buf_d   = im_rdata;
          state_d = HOLD;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          pc_d = tgt;
          if (im_ready) begin
            state_d = FETCH;
          end
        end else if (im_ready) begin
          // This is the stale response to the pre-redirect address.
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = tgt;
          state_d = FETCH;
        end else if (!stall) begin
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake decode from state plus same-cycle inputs.
  always_comb begin
    req_c   = 1'b0;
    deliver = 1'b0;
    kill    = 1'b0;
    case (state_q)
      FETCH: begin
        req_c   = 1'b1;
        kill    = redirect_valid;
        deliver = !redirect_valid && im_ready && !stall;
      end
      DRAIN: begin
        req_c = 1'b1;
        kill  = redirect_valid;
      end
      HOLD: begin
        kill    = redirect_valid;
        deliver = !redirect_valid && !stall;
      end
      default: ;
    endcase
  end

  // Control outputs are held quiet while reset is asserted.
  assign im_req      = rst_n & req_c;
  assign if_id_we    = rst_n & deliver;
  assign if_id_flush = rst_n & kill;

  assign im_addr     = pc_q;
  assign pc_add_out  = pc_inc;
  assign if_id_pc    = pc_q;
  assign if_id_inst  = (state_q == HOLD) ? buf_q : im_rdata;
  assign misalign    = misalign_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a table of per-cycle input/expected-output
// records plus a hand-written zero-wait run after reset.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, stall, redirect_valid, im_ready;
  logic [31:0] redirect_pc, im_rdata;
  logic        im_req, if_id_we, if_id_flush, misalign;
  logic [31:0] im_addr, pc_add_out, if_id_inst, if_id_pc, fetch_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .im_ready(im_ready), .im_rdata(im_rdata),
    .im_req(im_req), .im_addr(im_addr), .pc_add_out(pc_add_out),
    .if_id_we(if_id_we), .if_id_inst(if_id_inst), .if_id_pc(if_id_pc),
    .if_id_flush(if_id_flush), .misalign(misalign), .fetch_count(fetch_count)
  );

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_we;
    logic        e_flush;
    logic [31:0] e_inst;
    logic        e_mis;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic s, logic rv, logic [31:0] rpc,
                              logic rdy, logic [31:0] rd, logic req,
                              logic [31:0] addr, logic we, logic fl,
                              logic [31:0] inst, logic mis, logic [31:0] cnt);
    vec_t v;
    v.rst_n = r;  v.stall = s;  v.rv = rv;  v.rpc = rpc;  v.rdy = rdy;
    v.rdata = rd; v.e_req = req; v.e_addr = addr; v.e_we = we;
    v.e_flush = fl; v.e_inst = inst; v.e_mis = mis; v.e_cnt = cnt;
    return v;
  endfunction

  task automatic drive(logic r, logic s, logic rv, logic [31:0] rpc,
                       logic rdy, logic [31:0] rd);
    rst_n = r; stall = s; redirect_valid = rv; redirect_pc = rpc;
    im_ready = rdy; im_rdata = rd;
  endtask

  task automatic check(string name, vec_t v);
    logic ok;
    ok = (im_req === v.e_req) && (im_addr === v.e_addr) &&
         (if_id_pc === v.e_addr) && (pc_add_out === v.e_addr + 32'd4) &&
         (if_id_we === v.e_we) && (if_id_flush === v.e_flush) &&
         (misalign === v.e_mis) && (fetch_count === v.e_cnt) &&
         (!v.e_we || (if_id_inst === v.e_inst));
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got req=%b addr=%h pcadd=%h ifpc=%h we=%b fl=%b inst=%h mis=%b cnt=%0d | want req=%b addr=%h pcadd=%h we=%b fl=%b inst=%h mis=%b cnt=%0d",
               name, im_req, im_addr, pc_add_out, if_id_pc, if_id_we, if_id_flush,
               if_id_inst, misalign, fetch_count, v.e_req, v.e_addr,
               v.e_addr + 32'd4, v.e_we, v.e_flush, v.e_inst, v.e_mis, v.e_cnt);
    end
  endtask

  initial begin
    //            rst s rv rpc           rdy rdata         req addr          we fl inst          mis cnt
    vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3000, 0, 0, 32'h0,        0, 0)); // 0 reset held
    vq.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3000, 0, 0, 32'h0,        0, 0)); // 1 IDLE one cycle
    vq.push_back(mk(1, 0, 0, 32'h0,        1, 32'hA000_0000,1, 32'h0000_3000, 1, 0, 32'hA000_0000,0, 0)); // 2 zero-wait
    vq.push_back(mk(1, 0, 0, 32'h0,        1, 32'hA000_0001,1, 32'h0000_3004, 1, 0, 32'hA000_0001,0, 1)); // 3
    vq.push_back(mk(1, 0, 0, 32'h0,        1, 32'hA000_0002,1, 32'h0000_3008, 1, 0, 32'hA000_0002,0, 2)); // 4
    vq.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_300C, 0, 0, 32'h0,        0, 3)); // 5 count=3
    vq.push_back(mk(1, 1, 0, 32'h0,        1, 32'h8C01_0000,1, 32'h0000_300C, 0, 0, 32'h0,        0, 3)); // 6 stall on ready
    vq.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_300C, 0, 0, 32'h0,        0, 3)); // 7 HOLD
    vq.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_300C, 0, 0, 32'h0,        0, 3)); // 8 HOLD
    vq.push_back(mk(1, 0, 0, 32'h0,        0, 32'hDEAD_BEEF,0, 32'h0000_300C, 1, 0, 32'h8C01_0000,0, 3)); // 9 release delivers buf
    vq.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_3010, 0, 0, 32'h0,        0, 4)); // 10 next request
    vq.push_back(mk(1, 0, 1, 32'h0000_4000,0, 32'h0,        1, 32'h0000_3010, 0, 1, 32'h0,        0, 4)); // 11 redirect, old in flight
    vq.push_back(mk(1, 0, 0, 32'h0,        1, 32'hDEAD_0000,1, 32'h0000_4000, 0, 0, 32'h0,        0, 4)); // 12 DRAIN drops old word
    vq.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_4000, 0, 0, 32'h0,        0, 4)); // 13
    vq.push_back(mk(1, 0, 0, 32'h0,        1, 32'hB000_0000,1, 32'h0000_4000, 1, 0, 32'hB000_0000,0, 4)); // 14 deliver at 4000
    vq.push_back(mk(1, 0, 1, 32'h0000_5006,1, 32'hDEAD_0001,1, 32'h0000_4004, 0, 1, 32'h0,        0, 5)); // 15 misaligned redirect+ready
    vq.push_back(mk(1, 0, 0, 32'h0,        1, 32'hC000_0000,1, 32'h0000_5004, 1, 0, 32'hC000_0000,1, 5)); // 16 pc=5004 misalign
    vq.push_back(mk(1, 0, 1, 32'h0000_6000,0, 32'h0,        1, 32'h0000_5008, 0, 1, 32'h0,        1, 6)); // 17 -> DRAIN
    vq.push_back(mk(1, 0, 1, 32'h0000_7000,0, 32'h0,        1, 32'h0000_6000, 0, 1, 32'h0,        1, 6)); // 18 DRAIN redirect again
    vq.push_back(mk(1, 0, 1, 32'h0000_8000,1, 32'hDEAD_0002,1, 32'h0000_7000, 0, 1, 32'h0,        1, 6)); // 19 redirect+ready in DRAIN
    vq.push_back(mk(1, 0, 0, 32'h0,        1, 32'hD000_0000,1, 32'h0000_8000, 1, 0, 32'hD000_0000,1, 6)); // 20 latest target wins
    vq.push_back(mk(1, 1, 0, 32'h0,        1, 32'hE000_0000,1, 32'h0000_8004, 0, 0, 32'h0,        1, 7)); // 21 -> HOLD
    vq.push_back(mk(1, 1, 1, 32'h0000_9000,0, 32'h0,        0, 32'h0000_8004, 0, 1, 32'h0,        1, 7)); // 22 redirect in HOLD
    vq.push_back(mk(1, 0, 0, 32'h0,        1, 32'hF000_0000,1, 32'h0000_9000, 1, 0, 32'hF000_0000,1, 7)); // 23
    vq.push_back(mk(1, 0, 1, 32'hFFFF_FFFC,1, 32'hDEAD_0003,1, 32'h0000_9004, 0, 1, 32'h0,        1, 8)); // 24 to top of space
    vq.push_back(mk(1, 0, 0, 32'h0,        1, 32'h0000_0011,1, 32'hFFFF_FFFC, 1, 0, 32'h0000_0011,1, 8)); // 25 pc_add_out=0
    vq.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0000, 0, 0, 32'h0,        1, 9)); // 26 wrapped to 0
    vq.push_back(mk(1, 1, 0, 32'h0,        1, 32'h0000_0022,1, 32'h0000_0000, 0, 0, 32'h0,        1, 9)); // 27 -> HOLD
    vq.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0000, 0, 0, 32'h0,        1, 9)); // 28 reset in HOLD
    vq.push_back(mk(1, 1, 0, 32'h0,        1, 32'h0000_0033,0, 32'h0000_3000, 0, 0, 32'h0,        0, 0)); // 29 IDLE ignores response
    vq.push_back(mk(1, 0, 0, 32'h0,        1, 32'h0000_0044,1, 32'h0000_3000, 1, 0, 32'h0000_0044,0, 0)); // 30 first req after release
    vq.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_3004, 0, 0, 32'h0,        0, 1)); // 31
    vq.push_back(mk(0, 0, 1, 32'h0000_1000,1, 32'h0,        0, 32'h0000_3004, 0, 0, 32'h0,        0, 1)); // 32 reset masks flush
    vq.push_back(mk(1, 0, 1, 32'h0000_A000,0, 32'h0,        0, 32'h0000_3000, 0, 0, 32'h0,        0, 0)); // 33 IDLE redirect, no flush
    vq.push_back(mk(1, 0, 0, 32'h0,        1, 32'h0000_0055,1, 32'h0000_A000, 1, 0, 32'h0000_0055,0, 0)); // 34

    drive(0, 0, 0, 32'h0, 0, 32'h0);
    @(posedge clk); #1;

    foreach (vq[i]) begin
      drive(vq[i].rst_n, vq[i].stall, vq[i].rv, vq[i].rpc, vq[i].rdy, vq[i].rdata);
      @(negedge clk);
      check($sformatf("vec%0d", i), vq[i]);
      @(posedge clk); #1;
    end

    // Hand-written: reset then a zero-wait memory that answers whenever asked.
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("zw_idle", mk(1, 0, 0, 0, 0, 0, 0, 32'h0000_3000, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      im_ready = 1'b1;
      im_rdata = 32'h1234_0000 + k;
      @(negedge clk);
      check($sformatf("zw%0d", k),
            mk(1, 0, 0, 0, 1, 0, 1, 32'h0000_3000 + 32'(4 * k), 1, 0,
               32'h1234_0000 + k, 0, 32'(k)));
      @(posedge clk); #1;
    end
    im_ready = 1'b0;
    @(negedge clk);
    check("zw_count", mk(1, 0, 0, 0, 0, 0, 1, 32'h0000_3010, 0, 0, 0, 0, 4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the multistage pipeline: owns the PC register and drives the instruction-memory request/ready handshake. It delivers fetched words into IF/ID under the hazard unit's stall. Redirects (jr/jump/taken branch, already resolved by the next-PC mux) are accepted as a single valid+target pair. It also publishes PC+4 back to the next-PC mux and keeps a retired-fetch counter.

## Interface
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- stall  in  1  hazard unit holds IF/ID (load-use etc.).
- redirect_valid  in  1  control transfer taken this cycle (jr, jump, or branch).
- redirect_pc  in  32  target address; sampled only with redirect_valid.
- im_ready  in  1  instruction memory returns im_rdata this cycle.
- im_rdata  in  32  instruction word.
- im_req  out  1  fetch request; im_addr stable while high.
- im_addr  out  32  fetch address (= pc).
- pc_add_out  out  32  pc + 4 (to next-PC mux).
- if_id_we  out  1  write IF/ID with if_id_inst/if_id_pc.
- if_id_inst  out  32  instruction to IF/ID.
- if_id_pc  out  32  address of if_id_inst.
- if_id_flush  out  1  clear IF/ID to a bubble.
- misalign  out  1  sticky; a redirect target had bits [1:0] != 0.
- fetch_count  out  32  instructions written into IF/ID, wraps at 2^32.

## Operation
- States: IDLE, FETCH, DRAIN, HOLD. Registers: pc, state, buf (32 bits), misalign, fetch_count.
- Reset (rst_n=0 at an edge) sets the following:
  - state=IDLE, pc=RESET_PC, buf=0, misalign=0, fetch_count=0.
  - Combinational outputs during reset: im_req=0, if_id_we=0, if_id_flush=0.
- im_req=1 only in FETCH and DRAIN. im_addr=pc always. pc_add_out=pc+4, modulo 2^32 (32'hFFFF_FFFC gives 0).
- Target sanitising: tgt={redirect_pc[31:2],2'b00}. misalign sets when redirect_valid && redirect_pc[1:0]!=0 and stays set until reset.
- Redirect priority: redirect_valid overrides stall and im_ready in every state except IDLE.
  - if_id_flush=1 and if_id_we=0 in that same cycle.
  - pc<=tgt.
- IDLE: always goes to FETCH next cycle. A redirect in IDLE loads pc<=tgt with no flush.
- FETCH, ordered rules:
  - redirect && !im_ready: go to DRAIN; the in-flight response is discarded.
  - redirect && im_ready: the response is discarded; stay in FETCH.
  - im_ready && !stall: if_id_we=1, if_id_inst=im_rdata, if_id_pc=pc; pc<=pc+4; fetch_count++.
  - im_ready && stall: buf<=im_rdata; go to HOLD.
  - Otherwise: wait in FETCH.
- DRAIN: keeps im_req=1 at the new pc.
  - The first im_ready is discarded (the old response); go to FETCH.
  - A further redirect updates pc (latest wins).
  - A redirect coinciding with im_ready discards that response and goes to FETCH.
- HOLD: im_req=0; pc still addresses the buffered instruction.
  - When !stall: if_id_we=1, if_id_inst=buf, if_id_pc=pc; pc<=pc+4; fetch_count++; go to FETCH.
  - A redirect drops buf and goes to FETCH.
- if_id_inst=buf in HOLD, else im_rdata. if_id_pc=pc.

## Timing
- All state updates occur on the rising clk edge. Handshake outputs are combinational from state plus same-cycle inputs.
- First im_req: the cycle after the first edge with rst_n=1, i.e. IDLE lasts exactly one cycle.
- Zero-wait memory (im_ready in the same cycle as im_req): one instruction per cycle, no bubbles.
- Redirect-to-new-request latency: 1 cycle in FETCH (the request at the new pc is issued the next cycle). In DRAIN the new request is issued, but its data is accepted only after the old response has been discarded.
- Stall release from HOLD: delivery happens in the release cycle. The next request is issued the following cycle.
- Reset asserted mid-operation, in any state, applies the reset values at that edge. Any outstanding memory response is then ignored, because the block is in IDLE (no request).

## Test plan
- Reset with RESET_PC=32'h3000, zero-wait memory, no stall -> im_addr 3000, 3004, 3008 on consecutive cycles; fetch_count=3 after 3 deliveries.
- Stall raised while im_ready=1 at pc 3004 with rdata 8C010000 for 3 cycles -> state HOLD, im_req=0, if_id_we=0. On release: if_id_we=1 with inst 8C010000 and pc 3004; next im_addr=3008.
- Memory with 2-cycle latency; redirect_valid with redirect_pc=32'h4000 one cycle into the fetch of 3008 -> if_id_flush=1 that cycle. The returning old word is dropped (no if_id_we); next delivery has if_id_pc=4000.
- redirect_valid with redirect_pc=32'h5006 -> pc=5004 and misalign=1; misalign remains 1 until rst_n=0.
- pc=32'hFFFF_FFFC, zero-wait memory -> pc_add_out=0; next im_addr=0.
- rst_n dropped in HOLD with stall=1 -> next cycle state IDLE, pc=RESET_PC, im_req=0, fetch_count=0. The first im_req follows one cycle after reset release.
